// File: rtl/snake_pkg.sv
// snake_pkg
// Shared definitions for the snake game buffers.
//   BODY_DATA_WIDTH / BODY_DEPTH : default geometry of the body-segment queue
//   ptr_width()                  : FIFO pointer width (address bits plus one wrap bit)
package snake_pkg;

  localparam int BODY_DATA_WIDTH = 16;
  localparam int BODY_DEPTH      = 64;

  // One extra bit above the address lets equal addresses be told apart as
  // either "empty" (same lap) or "full" (writer one lap ahead).
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/snake_fifo_mem.sv
// snake_fifo_mem
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// asynchronous read port. Contents are never reset or cleared.
// Ports:
//   clk      in   write clock, rising edge
//   wr_en    in   store wr_data at wr_addr on the next edge
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  mem[rd_addr], combinational
module snake_fifo_mem
  import snake_pkg::*;
#(
  parameter int DATA_WIDTH = BODY_DATA_WIDTH,
  parameter int DEPTH      = BODY_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage has no reset so it can map onto plain register/LUT RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // The head word is read combinationally so the FIFO can fall through.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/snake_fifo.sv
// snake_fifo
// Single-clock first-word-fall-through FIFO with full/empty, occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and optional sticky
// error flags.
// Optional feature macro: SNAKE_FIFO_ERR_EN
//   defined   -> overflow/underflow are sticky registers
//   undefined -> overflow/underflow are tied to 0 (ports still present)
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   clear         synchronous flush, beats any write/read in the same cycle
//   wr_en/wr_data write request and data
//   rd_en         pop request
//   rd_data       head entry, 0 when empty
//   full, empty, almost_full, almost_empty, count   status from the pointers
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
module snake_fifo
  import snake_pkg::*;
#(
  parameter int DATA_WIDTH    = BODY_DATA_WIDTH,
  parameter int DEPTH         = BODY_DEPTH,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  localparam logic [PW-1:0] AFULL_CNT  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_CNT = PW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Status is decoded purely from the registered pointers, so it only moves
  // after a clock edge or reset.
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  // Both requests are judged against the pre-edge flags; a flush cancels both.
  assign wr_accept = wr_en && !full  && !clear;
  assign rd_accept = rd_en && !empty && !clear;

  // Next-state pointers: flush returns both to zero, otherwise each advances
  // only on an accepted request and wraps naturally at 2^PW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  snake_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  // Stale memory contents are masked so an empty FIFO always presents zero.
  assign rd_data = empty ? '0 : mem_rd_data;

`ifdef SNAKE_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: set by a rejected request, cleared only by flush or
  // reset. A flush in the same cycle wins over a new error.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en && full)  overflow_d  = 1'b1;
      if (rd_en && empty) underflow_d = 1'b1;
    end
  end

  // Error flag registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: doc/snake_fifo.md
# snake_fifo

Parametrised single-clock first-word-fall-through FIFO, the successor to the plain snake-body FIFO. Adds a true full flag, occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and optional sticky overflow/underflow error flags. Used for the snake body-segment queue and any other producer/consumer buffer in the game logic.

## Interface
- DATA_WIDTH, 16, bits per entry
- DEPTH, 64, entries; power of two, ≥ 2
- AFULL_THRESH, DEPTH-4, almost_full asserts when count ≥ this value
- AEMPTY_THRESH, 4, almost_empty asserts when count ≤ this value
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush; empties the FIFO
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read (pop) request
- rd_data  out  DATA_WIDTH  head entry; 0 when empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_THRESH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full (SNAKE_FIFO_ERR_EN only)
- underflow  out  1  sticky: read attempted while empty (SNAKE_FIFO_ERR_EN only)

## Operation
- Pointers wr_ptr, rd_ptr are $clog2(DEPTH)+1 bits; low bits address memory, MSB is wrap bit. Natural modulo-2^(AW+1) wrap.
- empty = (wr_ptr == rd_ptr); full = address bits equal, MSBs differ; count = wr_ptr − rd_ptr (unsigned, AW+1 bits).
- Write accepted iff wr_en && !full: memory[wr_ptr] ← wr_data, wr_ptr+1.
- Read accepted iff rd_en && !empty: rd_ptr+1. rd_data shows next entry after the edge.
- Simultaneous wr_en and rd_en: each judged on pre-edge flags. Not full and not empty: both accepted, count unchanged. Full: read accepted, write dropped. Empty: write accepted, read ignored. No write-through bypass.
- Dropped writes and ignored reads leave all state unchanged (except error flags).
- clear: pointers to 0, no write or read that cycle regardless of wr_en/rd_en, error flags cleared. Memory contents not cleared.
- rd_data = memory[rd_ptr] when !empty, else 0 (combinational read of head).
- Reset (any time, including mid-transfer): pointers 0, error flags 0; memory not reset.

## Timing
- Reset values: empty=1, full=0, count=0, almost_full=0, almost_empty=1, rd_data=0, overflow=0, underflow=0.
- All flags and count are combinational from registered pointers; they change only after a clk edge or rst.
- Write-to-read latency: 1 cycle. Word written at edge N is on rd_data, with empty=0, after edge N.
- Read latency: 0 cycles (FWFT). Head is valid whenever empty=0; rd_en pops at the next edge.
- Error flags set at the edge of the offending request and hold until rst or clear.

## Configuration
- SNAKE_FIFO_ERR_EN defined: overflow/underflow are sticky registers as described.
- Not defined: overflow and underflow are tied to 0 and no error registers are built. Ports remain present so instantiations do not change.

## Structure
- Shared package snake_pkg: pointer-width constant/function (clog2-based), and the default DATA_WIDTH/DEPTH for the body queue.
- One sub-module, snake_fifo_mem: DEPTH×DATA_WIDTH register array with one synchronous write port and one asynchronous read port. The top level holds the pointers, flags and error logic.

## Test plan
DATA_WIDTH=16, DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2 unless stated otherwise.
- Reset then idle → empty=1, full=0, count=0, almost_empty=1, rd_data=0.
- Write 0x0001..0x0008 on 8 consecutive cycles → count steps 1..8. almost_empty drops at count 3, almost_full rises at count 6, full=1 at 8. A 9th write of 0xDEAD is dropped and sets overflow (ERR_EN).
- From full, read 8 times → rd_data sequence 0x0001..0x0008, empty=1 after the 8th pop. An extra rd_en sets underflow; count stays 0.
- Hold count=4, then wr_en and rd_en together for 20 cycles → count stays 4, output stays in order across pointer wrap. Simultaneous wr+rd when full → read pops, write dropped, count=7.
- Fill to 5, assert clear with wr_en=1 → count=0, empty=1, error flags 0, written word not stored.
- Assert rst asynchronously mid-burst, between edges → all outputs return to reset values immediately. Normal writes resume after rst is released.
